// File: rtl/cpu_step_controller.sv
// cpu_step_controller
//   Sequences the multicycle CPU on the FPGA board. It produces a one-cycle
//   clock enable (cpu_en) for the CPU datapath, which runs on clk itself, so
//   no divided clocks exist anywhere in the design. The enable comes from one
//   of two sources:
//     - free-run: one pulse every DIV_COUNT clk cycles while run_sw is on;
//     - single-step: one pulse per debounced press of step_btn.
//   A second debounced button (sel_btn) rotates the seven-segment data-select
//   index. An executed-cycle counter tracks the enables issued.
//
// Optional feature: define BREAKPOINT_EN to add a PC breakpoint. The
//   compare happens at the divider terminal count in RUN. On a hit the pulse
//   is withheld and the controller parks in HALT until run_sw is turned off.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   run_sw       slide switch (async), 1 = free-run requested
//   step_btn     raw push button (async), press = one CPU cycle
//   sel_btn      raw push button (async), press = advance data_sel
//   pc           (BREAKPOINT_EN) current CPU program counter
//   bp_addr      (BREAKPOINT_EN) breakpoint address
//   bp_valid     (BREAKPOINT_EN) breakpoint armed
//   bp_hit       (BREAKPOINT_EN) registered, high while halted on breakpoint
//   cpu_en       registered one-cycle enable per CPU cycle
//   cycle_count  number of cpu_en pulses issued since reset
//   data_sel     display source index, 0..SEL_COUNT-1
//   state        current FSM state encoding
//
// FSM states:
//   state  | meaning
//   PAUSED | idle; waits for run_sw or a step press
//   RUN    | free-running; divider produces periodic cpu_en
//   STEP   | issue one cpu_en, then back to PAUSED
//   HALT   | stopped on breakpoint (BREAKPOINT_EN only); exits when run_sw=0

// Two-flop synchronizer, debounce filter and rising-edge press detector.
module btn_debounce #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;

  // The counter only advances while the synchronized input disagrees with
  // the accepted level; any agreement (a bounce back) restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      press_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
        press_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press = press_q;

endmodule

module cpu_step_controller #(
  parameter int DIV_COUNT       = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SEL_COUNT       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        sel_btn,
`ifdef BREAKPOINT_EN
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
  input  logic        bp_valid,
  output logic        bp_hit,
`endif
  output logic        cpu_en,
  output logic [31:0] cycle_count,
  output logic [2:0]  data_sel,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    PAUSED = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALT   = 2'b11
  } state_t;

  localparam int DW = $clog2(DIV_COUNT);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_COUNT - 1);
  localparam logic [2:0]    SEL_LAST = 3'(SEL_COUNT - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          cpu_en_q, cpu_en_d;
  logic [31:0]   cycle_count_q;
  logic [2:0]    data_sel_q;
  logic [1:0]    run_sync_q;
  logic          run_on;
  logic          step_press;
  logic          sel_press;
`ifdef BREAKPOINT_EN
  logic          bp_hit_q, bp_hit_d;
`endif

  // run_sw is a slide switch: it is synchronized but not debounced, since a
  // bounce only delays the RUN/PAUSED decision by a cycle or two.
  always_ff @(posedge clk) begin
    if (reset) run_sync_q <= 2'b00;
    else       run_sync_q <= {run_sync_q[0], run_sw};
  end
  assign run_on = run_sync_q[1];

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk   (clk),
    .reset (reset),
    .raw   (step_btn),
    .press (step_press)
  );

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_sel_db (
    .clk   (clk),
    .reset (reset),
    .raw   (sel_btn),
    .press (sel_press)
  );

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cpu_en_d = 1'b0;
`ifdef BREAKPOINT_EN
    bp_hit_d = bp_hit_q;
`endif
    case (state_q)
      PAUSED: begin
        // run_sw takes priority; a simultaneous step press is dropped.
        if (run_on) begin
          state_d = RUN;
          div_d   = '0;
        end else if (step_press) begin
          state_d = STEP;
        end
      end
      STEP: begin
        cpu_en_d = 1'b1;
        state_d  = PAUSED;
      end
      RUN: begin
        // Leaving RUN wins over a coincident terminal count.
        if (!run_on) begin
          state_d = PAUSED;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
`ifdef BREAKPOINT_EN
          if (bp_valid && (pc == bp_addr)) begin
            state_d  = HALT;
            bp_hit_d = 1'b1;
          end else begin
            cpu_en_d = 1'b1;
          end
`else
          cpu_en_d = 1'b1;
`endif
        end else begin
          div_d = div_q + DW'(1);
        end
      end
`ifdef BREAKPOINT_EN
      HALT: begin
        if (!run_on) begin
          state_d  = PAUSED;
          div_d    = '0;
          bp_hit_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = PAUSED;
        div_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= PAUSED;
      div_q         <= '0;
      cpu_en_q      <= 1'b0;
      cycle_count_q <= '0;
      data_sel_q    <= '0;
`ifdef BREAKPOINT_EN
      bp_hit_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cpu_en_q <= cpu_en_d;
`ifdef BREAKPOINT_EN
      bp_hit_q <= bp_hit_d;
`endif
      if (cpu_en_q) cycle_count_q <= cycle_count_q + 32'd1;
      if (sel_press) begin
        if (data_sel_q == SEL_LAST) data_sel_q <= '0;
        else                        data_sel_q <= data_sel_q + 3'd1;
      end
    end
  end

  assign cpu_en      = cpu_en_q;
  assign cycle_count = cycle_count_q;
  assign data_sel    = data_sel_q;
  assign state       = state_q;
`ifdef BREAKPOINT_EN
  assign bp_hit      = bp_hit_q;
`endif

endmodule

// File: tb/tb_cpu_step_controller.sv
// Testbench for cpu_step_controller (DIV_COUNT=4, DEBOUNCE_CYCLES=3,
// SEL_COUNT=6). Expected cpu_en pulses and data_sel changes are queued with
// the cycle at which they must appear; a monitor thread pops and compares
// them whenever the DUT produces a pulse or a data_sel change.
// Latencies from an input change applied after posedge k:
//   run_sw   -> FSM reacts at edge k+3, first pulse visible after edge k+7
//   step_btn -> cpu_en visible after edge k+7
//   sel_btn  -> data_sel visible after edge k+6
module tb_cpu_step_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        sel_btn = 1'b0;
  logic        cpu_en;
  logic [31:0] cycle_count;
  logic [2:0]  data_sel;
  logic [1:0]  state;
`ifdef BREAKPOINT_EN
  logic [31:0] pc = '0;
  logic [31:0] bp_addr = '0;
  logic        bp_valid = 1'b0;
  logic        bp_hit;
`endif

  cpu_step_controller #(
    .DIV_COUNT       (4),
    .DEBOUNCE_CYCLES (3),
    .SEL_COUNT       (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run_sw      (run_sw),
    .step_btn    (step_btn),
    .sel_btn     (sel_btn),
`ifdef BREAKPOINT_EN
    .pc          (pc),
    .bp_addr     (bp_addr),
    .bp_valid    (bp_valid),
    .bp_hit      (bp_hit),
`endif
    .cpu_en      (cpu_en),
    .cycle_count (cycle_count),
    .data_sel    (data_sel),
    .state       (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t pulse_q[$];
  exp_t sel_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  int   exp_sel = 0;
  bit   mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_pulse(input int at);
    exp_t e;
    e.cyc = at;
    e.val = exp_cnt;
    pulse_q.push_back(e);
    exp_cnt++;
  endtask

  task automatic push_sel(input int at, input int v);
    exp_t e;
    e.cyc = at;
    e.val = v;
    sel_q.push_back(e);
    exp_sel = v;
  endtask

  // Pulses for a run window starting now and lasting len cycles: terminal
  // counts every 4 edges from entry (k+3); the first edge seeing run_sw low
  // (k+len+3) suppresses its terminal count.
  task automatic push_run(input int len);
    int k = cyc;
    for (int t = k + 7; t < k + len + 3; t += 4) push_pulse(t);
  endtask

  task automatic do_reset();
    if (exp_sel != 0) push_sel(cyc + 1, 0);
    reset = 1'b1;
    tick(2);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    check("rst_data_sel", 32'(data_sel), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic step_press(input int hold);
    push_pulse(cyc + 7);
    step_btn = 1'b1;
    tick(hold);
    step_btn = 1'b0;
    tick(10);
  endtask

  task automatic monitor();
    logic [2:0] prev = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (cpu_en === 1'b1) begin
          total++;
          if (pulse_q.size() == 0) begin
            bad++;
            $display("FAIL cpu_en_pulse: unexpected pulse at cycle %0d count=%0d", cyc, cycle_count);
          end else begin
            e = pulse_q.pop_front();
            if (e.cyc != cyc || cycle_count !== 32'(e.val)) begin
              bad++;
              $display("FAIL cpu_en_pulse: got cycle %0d count %0d expected cycle %0d count %0d",
                       cyc, cycle_count, e.cyc, e.val);
            end
          end
        end
        if (data_sel !== prev) begin
          total++;
          if (sel_q.size() == 0) begin
            bad++;
            $display("FAIL data_sel_change: unexpected %0d at cycle %0d", data_sel, cyc);
          end else begin
            e = sel_q.pop_front();
            if (e.cyc != cyc || data_sel !== 3'(e.val)) begin
              bad++;
              $display("FAIL data_sel_change: got %0d at cycle %0d expected %0d at cycle %0d",
                       data_sel, cyc, e.val, e.cyc);
            end
          end
        end
      end
      prev = data_sel;
    end
  endtask

  int sel_exp [7] = '{1, 2, 3, 4, 5, 0, 1};

  initial begin
    int k;
    fork
      monitor();
    join_none
    @(negedge clk);

    // Reset, then idle: no pulses allowed.
    do_reset();
    mon_on = 1'b1;
    tick(50);
    check("idle_cycle_count", cycle_count, 32'd0);

    // Free-run for 40 cycles: 9 pulses, 4 apart, last terminal suppressed.
    push_run(40);
    run_sw = 1'b1;
    tick(10);
    check("run_state", 32'(state), 32'd1);
    tick(30);
    run_sw = 1'b0;
    tick(12);
    check("run_stop_state", 32'(state), 32'd0);
    check("run_cycle_count", cycle_count, 32'd9);

    // Step: glitch rejected, held press gives one pulse, re-press another.
    do_reset();
    step_btn = 1'b1;
    tick(2);
    step_btn = 1'b0;
    tick(12);
    check("glitch_cycle_count", cycle_count, 32'd0);
    step_press(10);
    check("step1_cycle_count", cycle_count, 32'd1);
    check("step1_state", 32'(state), 32'd0);
    step_press(10);
    check("step2_cycle_count", cycle_count, 32'd2);

    // Priority: run_sw reaches the FSM on the same edge as the step press.
    do_reset();
    k = cyc;
    step_btn = 1'b1;
    tick(3);
    push_run(30);
    run_sw = 1'b1;
    tick(3);
    check("prio_state", 32'(state), 32'd1);
    step_btn = 1'b0;
    tick(6);
    step_btn = 1'b1;
    tick(8);
    step_btn = 1'b0;
    tick(13);
    run_sw = 1'b0;
    tick(10);
    check("prio_stop_state", 32'(state), 32'd0);
    check("prio_cycle_count", cycle_count, 32'd7);
    if (cyc < k) check("prio_time", 32'(cyc), 32'(k));

    // data_sel wrap over seven presses.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      push_sel(cyc + 6, sel_exp[i]);
      sel_btn = 1'b1;
      tick(8);
      sel_btn = 1'b0;
      tick(8);
    end
    check("sel_final", 32'(data_sel), 32'd1);

    // Eighth press interrupted by reset just before it would be accepted.
    sel_btn = 1'b1;
    tick(3);
    sel_btn = 1'b0;
    do_reset();
    tick(20);
    check("sel_after_reset", 32'(data_sel), 32'd0);

`ifdef BREAKPOINT_EN
    // Breakpoint at first terminal count, exit via run_sw, step past it.
    do_reset();
    pc = 32'h8;
    bp_addr = 32'h8;
    bp_valid = 1'b1;
    run_sw = 1'b1;
    tick(8);
    check("bp_state", 32'(state), 32'd3);
    check("bp_hit_set", 32'(bp_hit), 32'd1);
    run_sw = 1'b0;
    tick(5);
    check("bp_exit_state", 32'(state), 32'd0);
    check("bp_hit_clear", 32'(bp_hit), 32'd0);
    step_press(10);
    check("bp_step_count", cycle_count, 32'd1);
    bp_valid = 1'b0;
`endif

    tick(5);
    check("pulse_queue_empty", 32'(pulse_q.size()), 32'd0);
    check("sel_queue_empty", 32'(sel_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
